counter_nx: RTL

Parametrised N-channel timer/counter peripheral on the MIO bus, clocked by the I/O clock. Each channel has its own prescaler, reload, compare and control registers and runs in one of four modes: stop, one-shot, periodic, or PWM. It raises per-channel sticky interrupt flags and drives per-channel outputs; `irq_any` feeds the CPU `INT` line. The CPU accesses it through a single channel/register write-and-read port.

---
 rtl/counter_nx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/counter_nx.sv
// counter_nx: N-channel timer/counter with per-channel prescaler, reload,
// compare and control registers. Modes: stop, one-shot, periodic, PWM.
// Sticky per-channel irq flags, irq_any gated by each channel's irq_en.
module counter_nx #(
    parameter int CH    = 4,
    parameter int W     = 32,
    parameter int PSC_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ch,
    input  logic [1:0]                          reg_sel,
    input  logic [W-1:0]                        wdata,
    output logic [W-1:0]                        rdata,
    output logic [CH-1:0]                       cnt_out,
    output logic [CH-1:0]                       irq,
    output logic                                irq_any
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    // Register select codes (reg 0 is RELOAD on write, COUNT on read).
    localparam logic [1:0] REG_CNT  = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_IRQ  = 2'd3;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_PWM      = 2'd3
    } mode_e;

    logic [W-1:0]     count_q  [CH];
    logic [W-1:0]     count_d  [CH];
    logic [W-1:0]     reload_q [CH];
    logic [W-1:0]     reload_d [CH];
    logic [W-1:0]     cmp_q    [CH];
    logic [W-1:0]     cmp_d    [CH];
    logic [W-1:0]     ctrl_q   [CH];
    logic [W-1:0]     ctrl_d   [CH];
    logic [PSC_W-1:0] psc_q    [CH];
    logic [PSC_W-1:0] psc_d    [CH];
    logic [PSC_W-1:0] psc_nxt  [CH];
    logic [CH-1:0]    done_q, done_d;
    logic [CH-1:0]    cnt_out_q, cnt_out_d;
    logic [CH-1:0]    irq_q, irq_d;
    logic [CH-1:0]    irq_set, irq_clr, irq_en_d;
    logic [CH-1:0]    ctrl_wr, tick, term;
    logic             irq_any_q, irq_any_d;
    logic [W-1:0]     rdata_q, rdata_d;

    // Per-channel CTRL write strobe, prescaler tick and terminal-event detect.
    always_comb begin
        ctrl_wr = '0;
        tick    = '0;
        term    = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            ctrl_wr[i] = we && (reg_sel == REG_CTRL) && (ch == CHW'(i));
            tick[i]    = (ctrl_q[i][1:0] != MODE_STOP)
                         && !((ctrl_q[i][1:0] == MODE_ONESHOT) && done_q[i])
                         && (psc_q[i] == ctrl_q[i][PSC_W+2:3]);
            term[i]    = tick[i] && (count_q[i] == '0);
            psc_nxt[i] = tick[i] ? '0 : psc_q[i] + PSC_W'(1);
        end
    end

    // Channel next-state: register writes, mode behaviour, irq set/clear.
    always_comb begin
        irq_set  = '0;
        irq_en_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            count_d[i]   = count_q[i];
            reload_d[i]  = reload_q[i];
            cmp_d[i]     = cmp_q[i];
            ctrl_d[i]    = ctrl_q[i];
            psc_d[i]     = psc_q[i];
            done_d[i]    = done_q[i];
            cnt_out_d[i] = cnt_out_q[i];

            if (we && (ch == CHW'(i)) && (reg_sel == REG_CNT)) begin
                reload_d[i] = wdata;
            end
            if (we && (ch == CHW'(i)) && (reg_sel == REG_CMP)) begin
                cmp_d[i] = wdata;
            end

            // A CTRL write restarts the channel and overrides any terminal event.
            if (ctrl_wr[i]) begin
                ctrl_d[i]    = wdata;
                count_d[i]   = reload_q[i];
                psc_d[i]     = '0;
                done_d[i]    = 1'b0;
                cnt_out_d[i] = 1'b0;
            end else begin
                unique case (mode_e'(ctrl_q[i][1:0]))
                    MODE_STOP: begin
                        psc_d[i]     = '0;
                        cnt_out_d[i] = 1'b0;
                    end
                    MODE_ONESHOT: begin
                        if (!done_q[i]) begin
                            psc_d[i] = psc_nxt[i];
                            if (term[i]) begin
                                cnt_out_d[i] = 1'b1;
                                done_d[i]    = 1'b1;
                                irq_set[i]   = 1'b1;
                            end else if (tick[i]) begin
                                count_d[i] = count_q[i] - W'(1);
                            end
                        end
                    end
                    MODE_PERIODIC: begin
                        psc_d[i]     = psc_nxt[i];
                        cnt_out_d[i] = term[i];
                        if (term[i]) begin
                            count_d[i] = reload_q[i];
                            irq_set[i] = 1'b1;
                        end else if (tick[i]) begin
                            count_d[i] = count_q[i] - W'(1);
                        end
                    end
                    MODE_PWM: begin
                        psc_d[i] = psc_nxt[i];
                        if (term[i]) begin
                            count_d[i] = reload_q[i];
                            irq_set[i] = 1'b1;
                        end else if (tick[i]) begin
                            count_d[i] = count_q[i] - W'(1);
                        end
                        cnt_out_d[i] = (count_d[i] < cmp_q[i]);
                    end
                    default: ;
                endcase
            end
            irq_en_d[i] = ctrl_d[i][2];
        end

        // Set wins over a simultaneous write-1-to-clear on the same bit.
        irq_clr   = (we && (reg_sel == REG_IRQ)) ? wdata[CH-1:0] : '0;
        irq_d     = (irq_q & ~irq_clr) | irq_set;
        irq_any_d = |(irq_d & irq_en_d);
    end

    // Read mux; out-of-range channel reads return zero.
    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (ch == CHW'(i)) begin
                unique case (reg_sel)
                    REG_CNT:  rdata_d = count_q[i];
                    REG_CTRL: rdata_d = ctrl_q[i];
                    REG_CMP:  rdata_d = cmp_q[i];
                    default:  rdata_d = W'(irq_q);
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                cmp_q[i]    <= '0;
                ctrl_q[i]   <= '0;
                psc_q[i]    <= '0;
            end
            done_q    <= '0;
            cnt_out_q <= '0;
            irq_q     <= '0;
            irq_any_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
                cmp_q[i]    <= cmp_d[i];
                ctrl_q[i]   <= ctrl_d[i];
                psc_q[i]    <= psc_d[i];
            end
            done_q    <= done_d;
            cnt_out_q <= cnt_out_d;
            irq_q     <= irq_d;
            irq_any_q <= irq_any_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign cnt_out = cnt_out_q;
    assign irq     = irq_q;
    assign irq_any = irq_any_q;

endmodule
